// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//   Register-file writeback arbiter with a pending-write scoreboard.
//   Two writeback sources (A = ALU, B = load unit) compete for a single
//   register-file write port. At most one request is accepted per cycle.
//   The accepted request appears on the registered write port in the
//   following cycle. A 32-bit scoreboard tracks destinations that have been
//   issued but not yet written back.
//
// Parameters
//   RR_EN     1: round-robin between A and B, 0: A always wins
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   a_valid   ALU writeback request
//   a_rd      ALU destination register
//   a_data    ALU result
//   a_ready   ALU request accepted this cycle (combinational)
//   b_valid   load-unit writeback request
//   b_rd      load-unit destination register
//   b_data    load-unit result
//   b_ready   load-unit request accepted this cycle (combinational)
//   iss_valid issue stage marks iss_rd as pending
//   iss_rd    destination being issued
//   wr        register-file write address (registered)
//   we        register-file write enable (registered, one pulse per write)
//   din       register-file write data (registered)
//   busy      scoreboard, bit n set while register n has a pending write
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic [4:0]  wr,
    output logic        we,
    output logic [31:0] din,
    output logic [31:0] busy
);

    // prefer_b_r = 1 means B wins the next contended cycle.
    logic        prefer_b_r;
    logic        we_r;
    logic [4:0]  wr_r;
    logic [31:0] din_r;
    logic [31:0] busy_r;

    logic        a_fire_s;
    logic        b_fire_s;
    logic        xfer_s;
    logic [4:0]  sel_rd_s;
    logic [31:0] sel_data_s;
    logic [31:0] set_mask_s;
    logic [31:0] clr_mask_s;
    logic [31:0] busy_nxt_s;

    // Grant selection; readiness never looks at the scoreboard.
    always_comb begin
        a_fire_s = 1'b0;
        b_fire_s = 1'b0;
        if (rst) begin
            a_fire_s = 1'b0;
            b_fire_s = 1'b0;
        end else if (a_valid && b_valid) begin
            if (RR_EN && prefer_b_r) begin
                b_fire_s = 1'b1;
            end else begin
                a_fire_s = 1'b1;
            end
        end else begin
            a_fire_s = a_valid;
            b_fire_s = b_valid;
        end
    end

    // Mux the winning request onto the write path.
    always_comb begin
        xfer_s     = a_fire_s | b_fire_s;
        sel_rd_s   = a_rd;
        sel_data_s = a_data;
        if (b_fire_s) begin
            sel_rd_s   = b_rd;
            sel_data_s = b_data;
        end else begin
            sel_rd_s   = a_rd;
            sel_data_s = a_data;
        end
    end

    // Scoreboard next state: clear on writeback, set on issue; set is applied
    // last so a same-edge issue of the same register keeps it pending.
    always_comb begin
        set_mask_s = 32'h0000_0000;
        clr_mask_s = 32'h0000_0000;
        if (iss_valid && (iss_rd != 5'd0)) begin
            set_mask_s = 32'h0000_0001 << iss_rd;
        end else begin
            set_mask_s = 32'h0000_0000;
        end
        if (xfer_s && (sel_rd_s != 5'd0)) begin
            clr_mask_s = 32'h0000_0001 << sel_rd_s;
        end else begin
            clr_mask_s = 32'h0000_0000;
        end
        busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
    end

    // Write port registers, round-robin pointer and scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prefer_b_r <= 1'b0;
            we_r       <= 1'b0;
            wr_r       <= 5'd0;
            din_r      <= 32'h0000_0000;
            busy_r     <= 32'h0000_0000;
        end else begin
            busy_r <= busy_nxt_s;
            if (xfer_s) begin
                // x0 writes still move wr/din but never pulse we.
                we_r  <= (sel_rd_s != 5'd0);
                wr_r  <= sel_rd_s;
                din_r <= sel_data_s;
            end else begin
                we_r <= 1'b0;
            end
            // Pointer moves only on a transfer; it stays at A when RR_EN=0.
            if (a_fire_s) begin
                prefer_b_r <= RR_EN;
            end else if (b_fire_s) begin
                prefer_b_r <= 1'b0;
            end else begin
                prefer_b_r <= prefer_b_r;
            end
        end
    end

    assign a_ready = a_fire_s;
    assign b_ready = b_fire_s;
    assign we      = we_r;
    assign wr      = wr_r;
    assign din     = din_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter. Two instances share stimulus:
// u_rr (RR_EN=1) is checked everywhere, u_fp (RR_EN=0) for fixed priority.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;

    logic        rr_a_ready, rr_b_ready, rr_we;
    logic [4:0]  rr_wr;
    logic [31:0] rr_din, rr_busy;
    logic        fp_a_ready, fp_b_ready, fp_we;
    logic [4:0]  fp_wr;
    logic [31:0] fp_din, fp_busy;

    int checks_cnt;
    int fail_cnt;

    rf_wb_arbiter #(.RR_EN(1'b1)) u_rr (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(rr_a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(rr_b_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .wr(rr_wr), .we(rr_we), .din(rr_din), .busy(rr_busy)
    );

    rf_wb_arbiter #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(fp_a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(fp_b_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .wr(fp_wr), .we(fp_we), .din(fp_din), .busy(fp_busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                         input logic iv, input logic [4:0] ird);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        iss_valid = iv; iss_rd = ird;
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Safety net: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst = 1'b1;
        drive(1'b1, 5'd4, 32'h1111_1111, 1'b1, 5'd6, 32'h2222_2222, 1'b1, 5'd8);
        #2;
        // Reset state, and no grant while in reset even with valids high.
        check_eq("rst_a_ready", {31'd0, rr_a_ready}, 32'd0);
        check_eq("rst_b_ready", {31'd0, rr_b_ready}, 32'd0);
        check_eq("rst_we",      {31'd0, rr_we},      32'd0);
        check_eq("rst_wr",      {27'd0, rr_wr},      32'd0);
        check_eq("rst_din",     rr_din,              32'd0);
        check_eq("rst_busy",    rr_busy,             32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single A write.
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        #1;
        check_eq("a1_a_ready", {31'd0, rr_a_ready}, 32'd1);
        check_eq("a1_b_ready", {31'd0, rr_b_ready}, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_eq("a1_we",  {31'd0, rr_we}, 32'd1);
        check_eq("a1_wr",  {27'd0, rr_wr}, 32'd5);
        check_eq("a1_din", rr_din,         32'hDEAD_BEEF);
        tick();
        check_eq("a1_we_off", {31'd0, rr_we}, 32'd0);

        // Single B write; hands the round-robin pointer back to A.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0);
        #1;
        check_eq("b1_b_ready", {31'd0, rr_b_ready}, 32'd1);
        check_eq("b1_a_ready", {31'd0, rr_a_ready}, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_eq("b1_we",  {31'd0, rr_we}, 32'd1);
        check_eq("b1_wr",  {27'd0, rr_wr}, 32'd3);
        check_eq("b1_din", rr_din,         32'h0000_0033);

        // Contention for 4 cycles: RR gives A,B,A,B with no gaps; fixed gives A.
        drive(1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_00B2, 1'b0, 5'd0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("rr_a_ready_%0d", k), {31'd0, rr_a_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("rr_b_ready_%0d", k), {31'd0, rr_b_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
            check_eq($sformatf("fp_a_ready_%0d", k), {31'd0, fp_a_ready}, 32'd1);
            check_eq($sformatf("fp_b_ready_%0d", k), {31'd0, fp_b_ready}, 32'd0);
            tick();
            check_eq($sformatf("rr_we_%0d", k),  {31'd0, rr_we}, 32'd1);
            check_eq($sformatf("rr_wr_%0d", k),  {27'd0, rr_wr}, (k % 2 == 0) ? 32'd1 : 32'd2);
            check_eq($sformatf("rr_din_%0d", k), rr_din, (k % 2 == 0) ? 32'h0000_00A1 : 32'h0000_00B2);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        tick();
        check_eq("cont_we_off", {31'd0, rr_we}, 32'd0);

        // Scoreboard: issue r7, clear by B write, then set+clear at one edge.
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_eq("sb_set", rr_busy, 32'h0000_0080);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_eq("sb_clr",    rr_busy,         32'h0000_0000);
        check_eq("sb_clr_wr", {27'd0, rr_wr},  32'd7);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        tick();
        drive(1'b1, 5'd7, 32'h0000_7777, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_eq("sb_set_wins", rr_busy,        32'h0000_0080);
        check_eq("sb_sw_we",    {31'd0, rr_we}, 32'd1);
        check_eq("sb_sw_din",   rr_din,         32'h0000_7777);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0007, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_eq("sb_clr2", rr_busy, 32'h0000_0000);

        // x0: issue and write r0.
        drive(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
        #1;
        check_eq("x0_a_ready", {31'd0, rr_a_ready}, 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_eq("x0_we",   {31'd0, rr_we}, 32'd0);
        check_eq("x0_wr",   {27'd0, rr_wr}, 32'd0);
        check_eq("x0_din",  rr_din,         32'h0000_1234);
        check_eq("x0_busy", rr_busy,        32'h0000_0000);
        tick();
        check_eq("x0_we2",  {31'd0, rr_we}, 32'd0);

        // Async reset between a transfer edge and its we pulse.
        drive(1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_eq("ar_pre_we",   {31'd0, rr_we}, 32'd1);
        check_eq("ar_pre_busy", rr_busy,        32'h0000_0400);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_we",   {31'd0, rr_we}, 32'd0);
        check_eq("ar_busy", rr_busy,        32'd0);
        check_eq("ar_wr",   {27'd0, rr_wr}, 32'd0);
        #2;
        rst = 1'b0;
        tick();
        check_eq("ar_idle_we1", {31'd0, rr_we}, 32'd0);
        tick();
        check_eq("ar_idle_we2", {31'd0, rr_we}, 32'd0);
        // The last pre-reset grant was A; reset must point back at A.
        drive(1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_00B2, 1'b0, 5'd0);
        #1;
        check_eq("ar_first_a", {31'd0, rr_a_ready}, 32'd1);
        check_eq("ar_first_b", {31'd0, rr_b_ready}, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check_eq("ar_first_wr", {27'd0, rr_wr}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with port A always winning.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 a_valid  input  1  ALU writeback request valid.
REQ-005 a_rd  input  5  ALU destination register.
REQ-006 a_data  input  32  ALU result.
REQ-007 a_ready  output  1  ALU request accepted this cycle (combinational).
REQ-008 b_valid, b_rd, b_data, b_ready  as REQ-004..007, 1/5/32/1 bits  load-unit writeback port.
REQ-009 iss_valid  input  1  issue stage marks a destination as pending.
REQ-010 iss_rd  input  5  destination being issued.
REQ-011 wr  output  5  register-file write address (registered).
REQ-012 we  output  1  register-file write enable (registered, 1-cycle pulse).
REQ-013 din  output  32  register-file write data (registered).
REQ-014 busy  output  32  scoreboard; bit n=1 means register n has an issued, uncommitted write.

Function
REQ-015 Handshake: a transfer on a port occurs in a cycle where valid and ready are both 1 at the rising edge.
REQ-016 Only valid requesters are granted; ready SHALL be 0 whenever the matching valid is 0.
REQ-017 One valid requester: it is granted (ready=1) in the same cycle.
REQ-018 Both valid, RR_EN=1: grant goes to the port not granted in the most recent transfer; the pointer updates only on a transfer.
REQ-019 Both valid, RR_EN=0: A is granted; B waits.
REQ-020 With RR_EN=1 and both ports continuously valid, grants alternate A,B,A,B; no port waits more than 1 cycle.
REQ-021 Latency: a transfer at edge t drives wr/din from the granted port and we=1 during cycle t+1; we returns to 0 in cycle t+2 unless another transfer occurred at edge t+1.
REQ-022 Throughput: one transfer per cycle, back-to-back, with no bubbles.
REQ-023 Writes to rd=0 are accepted but produce we=0; wr and din still update.
REQ-024 Scoreboard set: iss_valid with iss_rd!=0 sets busy[iss_rd] at the next edge.
REQ-025 Scoreboard clear: a transfer with rd!=0 clears busy[rd] at the same edge the write is registered.
REQ-026 Set and clear of the same register at the same edge: set wins, and busy stays 1.
REQ-027 busy[0] is constantly 0.
REQ-028 Transfers to a register whose busy bit is 0 are legal and clear nothing.
REQ-029 Ready does not depend on busy.

Reset
REQ-030 While rst=1, asynchronously: we=0, wr=0, din=0, busy=0, and the round-robin pointer favours A next.
REQ-031 Reset mid-operation drops any registered write; no we pulse appears after rst deasserts until a new transfer.
REQ-032 a_ready and b_ready are 0 while rst=1.

Verification
REQ-033 Single A write: a_valid=1, a_rd=5, a_data=0xDEADBEEF for 1 cycle -> a_ready=1 that cycle; the next cycle shows we=1, wr=5, din=0xDEADBEEF; the cycle after shows we=0.
REQ-034 Contention, RR_EN=1: both valid for 4 cycles (A rd=1, B rd=2) -> grants A,B,A,B; the we stream shows wr 1,2,1,2 with no gaps.
REQ-035 Contention, RR_EN=0: both valid for 3 cycles -> a_ready=1 and b_ready=0 for all 3 cycles.
REQ-036 Scoreboard: issue rd=7 -> busy[7]=1; a later B write rd=7 -> busy[7]=0 after that edge; issue rd=7 plus A write rd=7 at the same edge -> busy[7] stays 1.
REQ-037 x0: issue rd=0 and write rd=0 with data 0x1234 -> busy=0 and we=0 throughout.
REQ-038 Async reset: assert rst mid-cycle in the cycle between a transfer edge and its we pulse -> we=0 immediately and busy=0; after release, outputs stay idle and the first contention grants A.
